vec_copy_seq: RTL and testbench

Parametrised, multi-cycle vector copy engine that transfers a WIDTH-bit input vector to a registered output, CHUNK bits per clock. An optional bit-reversal mode mirrors the vector end-to-end. It generalises the fixed 128-bit combinational bit-copy loop into a sequential, handshaked block. It is intended for the SV regression suite, where it exercises loop-counter width, partial-vector writes and FSM handling.

---
 rtl/vec_copy_seq.sv | 143 ++++++++++++++
 tb/tb_vec_copy_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_copy_seq.sv
// vec_copy_seq
//   Sequential vector copy engine. A start request in IDLE captures the
//   source vector and the mirror mode, then the engine writes the
//   destination register CHUNK bits per clock, lowest chunk first. After
//   the last chunk it returns to IDLE and pulses done for one cycle.
//
// Parameters
//   WIDTH  vector width in bits (>= 1)
//   CHUNK  bits written per clock; must divide WIDTH
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous, active-high reset
//   start  copy request, sampled only in IDLE
//   rev    0 = straight copy, 1 = bit-reversed copy (sampled with start)
//   in     source vector (sampled with start)
//   busy   high while a copy is in progress
//   done   one-cycle pulse after the final chunk has been written
//   out    destination register
module vec_copy_seq #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rev,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // One extra count of headroom so NCHUNK itself is representable.
    localparam int CW = $clog2(NCHUNK + 1);

    localparam logic [CW-1:0]    LAST_IDX   = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("vec_copy_seq: CHUNK must be >= 1 and divide WIDTH (>= 1)");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shadow;
    logic             rev_q;
    logic [CW-1:0]    idx;
    logic             last;

    // Bit offset of chunk k, computed at full integer width so large
    // WIDTH/CHUNK ratios never truncate.
    function automatic int chunk_off(input logic [CW-1:0] k);
        return int'(k) * CHUNK;
    endfunction

    // Chunk k of the source as it should land in out. In mirror mode the
    // whole vector is reversed first, so chunk bit b comes from
    // src[WIDTH-1-(k*CHUNK+b)].
    function automatic logic [CHUNK-1:0] pick_chunk(
        input logic [WIDTH-1:0] src,
        input logic             mirror,
        input logic [CW-1:0]    k
    );
        logic [WIDTH-1:0] oriented;
        if (mirror) begin
            oriented = {<<{src}};
        end else begin
            oriented = src;
        end
        return CHUNK'(oriented >> chunk_off(k));
    endfunction

    // Replace chunk k of old with data, leaving every other bit untouched.
    function automatic logic [WIDTH-1:0] merge_chunk(
        input logic [WIDTH-1:0] old,
        input logic [CHUNK-1:0] data,
        input logic [CW-1:0]    k
    );
        logic [WIDTH-1:0] mask;
        mask = CHUNK_MASK << chunk_off(k);
        return (old & ~mask) | (WIDTH'(data) << chunk_off(k));
    endfunction

    assign last = (idx == LAST_IDX);
    // busy decodes the state flop directly, so it is still a registered output.
    assign busy = (state == COPY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = COPY;
            COPY: if (last)  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            shadow <= '0;
            rev_q  <= 1'b0;
            idx    <= '0;
            out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // out is deliberately left alone on start.
                    if (start) begin
                        shadow <= in;
                        rev_q  <= rev;
                        idx    <= '0;
                    end
                end
                COPY: begin
                    out <= merge_chunk(out, pick_chunk(shadow, rev_q, idx), idx);
                    if (last) begin
                        done <= 1'b1;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_copy_seq.sv
module tb_vec_copy_seq;

    logic clk;
    logic rst;

    // Main instance: WIDTH=128, CHUNK=8
    logic         s8, r8, busy8, done8;
    logic [127:0] in8, out8;
    // CHUNK = WIDTH = 128
    logic         sA, rA, busyA, doneA;
    logic [127:0] inA, outA;
    // WIDTH=128, CHUNK=1
    logic         s1, r1, busy1, done1;
    logic [127:0] in1, out1;
    // WIDTH=1, CHUNK=1
    logic         sW, rW, busyW, doneW;
    logic         inW, outW;

    int n_assert;
    int n_fail;
    logic [127:0] out_e4;

    vec_copy_seq #(.WIDTH(128), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .rev(r8), .in(in8),
        .busy(busy8), .done(done8), .out(out8));
    vec_copy_seq #(.WIDTH(128), .CHUNK(128)) dutA (
        .clk(clk), .rst(rst), .start(sA), .rev(rA), .in(inA),
        .busy(busyA), .done(doneA), .out(outA));
    vec_copy_seq #(.WIDTH(128), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .rev(r1), .in(in1),
        .busy(busy1), .done(done1), .out(out1));
    vec_copy_seq #(.WIDTH(1), .CHUNK(1)) dutW (
        .clk(clk), .rst(rst), .start(sW), .rev(rW), .in(inW),
        .busy(busyW), .done(doneW), .out(outW));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: mirrored vector, out[127-j] = in[j].
    function automatic logic [127:0] mirror128(input logic [127:0] x);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[127-j] = x[j];
        return r;
    endfunction

    // Reference: after nbits have been copied, the low nbits equal the
    // target and the rest still hold the previous destination contents.
    function automatic logic [127:0] partial(input logic [127:0] prev,
                                             input logic [127:0] tgt,
                                             input int nbits);
        logic [127:0] r;
        for (int j = 0; j < 128; j++) r[j] = (j < nbits) ? tgt[j] : prev[j];
        return r;
    endfunction

    // One full copy on the CHUNK=8 instance, checked at every edge.
    task automatic run8(input logic [127:0] v, input logic r, input string name);
        logic [127:0] prev;
        logic [127:0] tgt;
        prev = out8;
        tgt  = r ? mirror128(v) : v;
        in8 = v; r8 = r; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        in8 = rnd128();
        chk({name, " busy@E0"}, busy8, 1'b1);
        chk({name, " done@E0"}, done8, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 4) out_e4 = out8;
            chk($sformatf("%s out@E%0d", name, k), out8, partial(prev, tgt, 8 * k));
            chk($sformatf("%s busy@E%0d", name, k), busy8, (k < 16));
            chk($sformatf("%s done@E%0d", name, k), done8, (k == 16));
        end
        tick();
        chk({name, " done drops"}, done8, 1'b0);
        chk({name, " final out"}, out8, tgt);
    endtask

    initial begin
        logic [127:0] a, b, v;
        int t1, t2, npulse, lat;
        logic [127:0] o1, o2;

        n_assert = 0; n_fail = 0;
        rst = 1'b1;
        s8 = 0; r8 = 0; in8 = '0;
        sA = 0; rA = 0; inA = '0;
        s1 = 0; r1 = 0; in1 = '0;
        sW = 0; rW = 0; inW = 0;

        // Reset state (reset applied before any clock edge)
        #3;
        chk("reset out8", out8, '0);
        chk("reset busy8", busy8, 1'b0);
        chk("reset done8", done8, 1'b0);
        chk("reset outA", outA, '0);
        chk("reset out1", out1, '0);
        chk("reset outW", outW, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Straight copy of the directed vector
        run8(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, "straight");
        chk("straight E4 low", out_e4[31:0], 32'h76543210);
        chk("straight E4 high", out_e4[127:32], '0);
        chk("straight literal", out8, 128'h0123456789ABCDEF_FEDCBA9876543210);

        // Reversed copies
        run8(128'h1, 1'b1, "rev1");
        chk("rev1 literal", out8, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        run8({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, "revhalf");
        chk("revhalf literal", out8, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

        // Random copies in both modes
        for (int i = 0; i < 3; i++) begin
            v = rnd128();
            run8(v, i[0], $sformatf("rand%0d", i));
        end

        // Start and input changes during a copy are ignored
        in8 = '1; r8 = 1'b0; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            in8 = ~in8;
            if (k == 4) begin
                s8 = 1'b1; in8 = '0; r8 = 1'b1;
            end
            if (k == 5) s8 = 1'b0;
            tick();
            chk($sformatf("ignore done@E%0d", k), done8, (k == 16));
        end
        chk("ignore out", out8, '1);
        tick();
        chk("ignore idle after", busy8, 1'b0);

        // Reset in the middle of a copy
        in8 = rnd128(); r8 = 1'b0; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out", out8, '0);
        chk("midrst busy", busy8, 1'b0);
        chk("midrst done", done8, 1'b0);
        tick();
        rst = 1'b0;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8 === 1'b1) npulse++;
        end
        chk("midrst no done", npulse, 0);
        chk("midrst out held", out8, '0);
        run8(rnd128(), 1'b1, "afterrst");

        // Back-to-back with start held high
        a = rnd128();
        b = rnd128();
        in8 = a; r8 = 1'b0; s8 = 1'b1;
        tick();
        in8 = b;
        t1 = -1; t2 = -1; o1 = '0; o2 = '0;
        for (int t = 1; t <= 33; t++) begin
            tick();
            if (done8 === 1'b1) begin
                if (t1 < 0) begin t1 = t; o1 = out8; end
                else if (t2 < 0) begin t2 = t; o2 = out8; end
            end
        end
        s8 = 1'b0;
        chk("b2b first done", t1, 16);
        chk("b2b second done", t2, 33);
        chk("b2b out A", o1, a);
        chk("b2b out B", o2, b);
        tick();
        chk("b2b idle", busy8, 1'b0);

        // CHUNK = WIDTH: one-edge latency
        for (int m = 0; m < 2; m++) begin
            v = rnd128();
            inA = v; rA = m[0]; sA = 1'b1;
            tick();
            sA = 1'b0;
            inA = ~v;
            chk($sformatf("c128 busy@E0 m%0d", m), busyA, 1'b1);
            tick();
            chk($sformatf("c128 done@E1 m%0d", m), doneA, 1'b1);
            chk($sformatf("c128 busy@E1 m%0d", m), busyA, 1'b0);
            chk($sformatf("c128 out m%0d", m), outA, m[0] ? mirror128(v) : v);
            tick();
        end

        // CHUNK = 1: 128-edge latency
        for (int m = 0; m < 2; m++) begin
            v = rnd128();
            in1 = v; r1 = m[0]; s1 = 1'b1;
            tick();
            s1 = 1'b0;
            lat = -1;
            for (int c = 1; c <= 200; c++) begin
                tick();
                if (done1 === 1'b1) begin lat = c; break; end
            end
            chk($sformatf("c1 latency m%0d", m), lat, 128);
            chk($sformatf("c1 out m%0d", m), out1, m[0] ? mirror128(v) : v);
            tick();
        end

        // WIDTH = 1: both modes, both bit values
        for (int m = 0; m < 4; m++) begin
            inW = m[0]; rW = m[1]; sW = 1'b1;
            tick();
            sW = 1'b0;
            inW = ~m[0];
            tick();
            chk($sformatf("w1 done m%0d", m), doneW, 1'b1);
            chk($sformatf("w1 out m%0d", m), outW, m[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
